// File: rtl/alu_arb_pkg.sv
// Shared constants and state encoding for the ALU share arbiter and its picker.
package alu_arb_pkg;

    localparam int W_DEF    = 8;
    localparam int NREQ_MAX = 4;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_MUL = 2'b10;

    typedef enum logic {
        ST_OPEN  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first asserted request
// scanning upward from ptr_i+1, wrapping modulo N.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr_i) + off) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters, with
// per-requester lock. Optional statistics ports under macro ALU_ARB_STATS_EN.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*W-1:0] op_first,
    input  logic [NREQ*W-1:0] op_second,
    input  logic [NREQ-1:0]   op_mul,
    input  logic [NREQ-1:0]   op_sub,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic [W-1:0]      first_alu,
    output logic [W-1:0]      second_alu,
    output logic              mul,
    output logic              sub,
    input  logic [W-1:0]      result_of_alu,
    output logic              busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0] grant_cnt,
    output logic [7:0]         wait_max
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]    first_q, first_d;
    logic [W-1:0]    second_q, second_d;
    logic            mul_q, mul_d;
    logic            sub_q, sub_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0] rr_gnt;
    logic            accept;
    logic [IW-1:0]   acc_idx;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt)
    );

    // While owned, only the owner can be granted, and only when it requests.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (state_q == ST_OPEN) gnt = rr_gnt;
            else if (req[owner_q])  gnt[owner_q] = 1'b1;
        end
    end

    assign accept = |gnt;

    always_comb begin
        acc_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) acc_idx = IW'(i);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        first_d     = first_q;
        second_d    = second_q;
        mul_d       = mul_q;
        sub_d       = sub_q;
        rsp_valid_d = '0;
        if (accept) begin
            first_d     = op_first[int'(acc_idx)*W +: W];
            second_d    = op_second[int'(acc_idx)*W +: W];
            mul_d       = op_mul[acc_idx];
            sub_d       = op_sub[acc_idx];
            rsp_valid_d = gnt;
            ptr_d       = acc_idx;
            if (lock[acc_idx]) begin
                state_d = ST_OWNED;
                owner_d = acc_idx;
            end else begin
                state_d = ST_OPEN;
            end
        end else if (state_q == ST_OWNED && !lock[owner_q]) begin
            // Owner idle and no longer locking: release without an op.
            state_d = ST_OPEN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OPEN;
            owner_q     <= '0;
            ptr_q       <= PTR_RST;
            first_q     <= '0;
            second_q    <= '0;
            mul_q       <= 1'b0;
            sub_q       <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            first_q     <= first_d;
            second_q    <= second_d;
            mul_q       <= mul_d;
            sub_q       <= sub_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign first_alu  = first_q;
    assign second_alu = second_q;
    assign mul        = mul_q;
    assign sub        = sub_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = result_of_alu;
    assign busy       = (state_q == ST_OWNED);

`ifdef ALU_ARB_STATS_EN
    logic [NREQ-1:0][15:0] gcnt_q, gcnt_d;
    logic [NREQ-1:0][7:0]  wcnt_q, wcnt_d;
    logic [7:0]            wmax_q, wmax_d;

    always_comb begin
        gcnt_d = gcnt_q;
        wcnt_d = wcnt_q;
        wmax_d = wmax_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && gcnt_q[i] != 16'hFFFF) gcnt_d[i] = gcnt_q[i] + 16'd1;
            if (req[i] && !gnt[i])
                wcnt_d[i] = (wcnt_q[i] == 8'hFF) ? 8'hFF : wcnt_q[i] + 8'd1;
            else
                wcnt_d[i] = 8'd0;
            if (wcnt_d[i] > wmax_d) wmax_d = wcnt_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_q <= '0;
            wcnt_q <= '0;
            wmax_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
            wcnt_q <= wcnt_d;
            wmax_q <= wmax_d;
        end
    end

    assign grant_cnt = gcnt_q;
    assign wait_max  = wmax_q;
`endif

endmodule
